// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_responder_pkg;

    localparam int DMEM_DATA_W     = 16;
    localparam int DMEM_ADDR_BUS_W = 16;
    localparam int DMEM_CNT_W      = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bus between pipeline stage 4 and the data-memory responder.
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high. The requester keeps req_valid (and its payload)
// steady while stall is high. rsp_valid is a single-cycle strobe with no
// back-pressure; rsp_err qualifies it. rsp_rdata/rsp_err hold between strobes.
interface dmem_responder_if
    import dmem_responder_pkg::*;
#(
    parameter int DATA_W = DMEM_DATA_W
);
    logic                       req_valid;
    logic                       req_we;
    logic [DMEM_ADDR_BUS_W-1:0] req_addr;
    logic [DATA_W-1:0]          req_wdata;
    logic                       req_ready;
    logic                       rsp_valid;
    logic [DATA_W-1:0]          rsp_rdata;
    logic                       rsp_err;
    logic                       stall;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, stall
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, stall
    );
endinterface

// File: rtl/dmem_responder_array.sv
// Single-port word RAM with registered read; contents are never reset.
module dmem_array #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
) (
    input  logic              CLK,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Write when enabled; read the addressed word (old contents) every edge.
    always_ff @(posedge CLK) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end
endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: services stage-4 loads/stores with a fixed number of
// wait states, raises stall while busy and flags out-of-range addresses.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = DMEM_DATA_W,
    parameter int WAIT_CYCLES = 2
) (
    input  logic            CLK,
    input  logic            RST,
    dmem_responder_if.slave bus,
    output dmem_state_t     fsm_state
);
    localparam bit ZERO_WAIT   = (WAIT_CYCLES == 0);
    localparam int WAIT_LOAD_I = ZERO_WAIT ? 0 : WAIT_CYCLES - 1;
    localparam logic [DMEM_CNT_W-1:0] WAIT_LOAD = WAIT_LOAD_I[DMEM_CNT_W-1:0];

    dmem_state_t                state_q, state_d;
    logic [DMEM_CNT_W-1:0]      cnt_q;
    logic                       lat_we;
    logic [DMEM_ADDR_BUS_W-1:0] lat_addr;
    logic [DATA_W-1:0]          lat_wdata;
    logic                       pend_err, pend_store;
    logic [DATA_W-1:0]          pend_wdata;
    logic [DATA_W-1:0]          hold_rdata;
    logic                       hold_err;
    logic                       accept, commit, acc_we, in_range, ram_we;
    logic [DMEM_ADDR_BUS_W-1:0] acc_addr;
    logic [DATA_W-1:0]          acc_wdata, ram_rdata, fresh_rdata;

    assign accept = (state_q == IDLE) && bus.req_valid;
    assign commit = (accept && ZERO_WAIT) || ((state_q == WAIT) && (cnt_q == '0));

    // A zero-wait commit happens in IDLE while the request is still on the bus;
    // every other commit uses the copy latched at acceptance.
    assign acc_we    = (state_q == IDLE) ? bus.req_we    : lat_we;
    assign acc_addr  = (state_q == IDLE) ? bus.req_addr  : lat_addr;
    assign acc_wdata = (state_q == IDLE) ? bus.req_wdata : lat_wdata;
    assign in_range  = (acc_addr[DMEM_ADDR_BUS_W-1:ADDR_W] == '0);

    // Reset in the commit cycle suppresses the write.
    assign ram_we = commit && acc_we && in_range && RST;

    dmem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .CLK   (CLK),
        .we    (ram_we),
        .addr  (acc_addr[ADDR_W-1:0]),
        .wdata (acc_wdata),
        .rdata (ram_rdata)
    );

    // Response word for the RESP cycle; load data comes straight from the RAM
    // read register filled on the commit edge.
    assign fresh_rdata = pend_err ? '0 : (pend_store ? pend_wdata : ram_rdata);

    // State register.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = ZERO_WAIT ? RESP : WAIT;
            WAIT:    if (cnt_q == '0) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request latch, wait counter, commit capture and held response registers.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            cnt_q      <= '0;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            pend_err   <= 1'b0;
            pend_store <= 1'b0;
            pend_wdata <= '0;
            hold_rdata <= '0;
            hold_err   <= 1'b0;
        end else begin
            if (accept) begin
                lat_we    <= bus.req_we;
                lat_addr  <= bus.req_addr;
                lat_wdata <= bus.req_wdata;
                cnt_q     <= WAIT_LOAD;
            end else if ((state_q == WAIT) && (cnt_q != '0)) begin
                cnt_q <= cnt_q - DMEM_CNT_W'(1);
            end
            if (commit) begin
                pend_err   <= !in_range;
                pend_store <= acc_we;
                pend_wdata <= acc_wdata;
            end
            if (state_q == RESP) begin
                hold_rdata <= fresh_rdata;
                hold_err   <= pend_err;
            end
        end
    end

    // Outputs: ready only in IDLE, stall while a request is being serviced.
    always_comb begin
        bus.req_ready = (state_q == IDLE);
        bus.stall     = accept || (state_q == WAIT);
        bus.rsp_valid = (state_q == RESP);
        bus.rsp_rdata = hold_rdata;
        bus.rsp_err   = hold_err;
        if (state_q == RESP) begin
            bus.rsp_rdata = fresh_rdata;
            bus.rsp_err   = pend_err;
        end
    end

    assign fsm_state = state_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a two-wait-state instance and a zero-wait
// instance, driven with directed and random traffic against a word-level model.
module tb_dmem_responder;
    import dmem_responder_pkg::*;

    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int WA     = 2;
    localparam int WB     = 0;

    typedef struct {
        logic [15:0] data;
        logic        err;
        int          acc;
    } exp_t;

    logic        clk   = 1'b0;
    logic        rst_a = 1'b0;
    logic        rst_b = 1'b0;
    dmem_state_t fsm_a, fsm_b;
    int          cyc     = 0;
    int          n_tests = 0;
    int          n_fail  = 0;

    exp_t        q_a[$];
    exp_t        q_b[$];
    logic [15:0] mem_a[int];
    logic [15:0] mem_b[int];
    logic [15:0] last_d_a = '0;
    logic [15:0] last_d_b = '0;
    logic        last_e_a = 1'b0;
    logic        last_e_b = 1'b0;

    dmem_responder_if #(.DATA_W(16)) bus_a ();
    dmem_responder_if #(.DATA_W(16)) bus_b ();

    dmem_responder #(.ADDR_W(ADDR_W), .DATA_W(16), .WAIT_CYCLES(WA)) u_dut_a (
        .CLK       (clk),
        .RST       (rst_a),
        .bus       (bus_a),
        .fsm_state (fsm_a)
    );

    dmem_responder #(.ADDR_W(ADDR_W), .DATA_W(16), .WAIT_CYCLES(WB)) u_dut_b (
        .CLK       (clk),
        .RST       (rst_b),
        .bus       (bus_b),
        .fsm_state (fsm_b)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic fail_only(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    task automatic drive(input int k, input logic v, input logic we, input logic [15:0] a, input logic [15:0] d);
        if (k == 0) begin
            bus_a.req_valid = v; bus_a.req_we = we; bus_a.req_addr = a; bus_a.req_wdata = d;
        end else begin
            bus_b.req_valid = v; bus_b.req_we = we; bus_b.req_addr = a; bus_b.req_wdata = d;
        end
    endtask

    function automatic logic ready_of(input int k);
        return (k == 0) ? bus_a.req_ready : bus_b.req_ready;
    endfunction

    function automatic logic [15:0] lookup(input int k, input logic [15:0] a);
        if (k == 0) return mem_a.exists(int'(a)) ? mem_a[int'(a)] : 16'h0;
        return mem_b.exists(int'(a)) ? mem_b[int'(a)] : 16'h0;
    endfunction

    // Wait for ready (scrambling the bus while busy), present one request and
    // record what the word-level model says the response must be.
    task automatic issue(input int k, input logic we, input logic [15:0] a, input logic [15:0] d);
        int   budget;
        exp_t e;
        budget = 0;
        @(negedge clk);
        while (!ready_of(k)) begin
            drive(k, (k == 1) ? 1'b1 : 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  16'($urandom), 16'($urandom));
            budget++;
            if (budget > 40) begin
                fail_only("issue_ready_timeout");
                drive(k, 1'b0, 1'b0, 16'h0, 16'h0);
                return;
            end
            @(negedge clk);
        end
        drive(k, 1'b1, we, a, d);
        e.acc = cyc;
        e.err = (int'(a) >= DEPTH);
        if (e.err) begin
            e.data = 16'h0;
        end else if (we) begin
            e.data = d;
            if (k == 0) mem_a[int'(a)] = d; else mem_b[int'(a)] = d;
        end else begin
            e.data = lookup(k, a);
        end
        if (k == 0) q_a.push_back(e); else q_b.push_back(e);
        @(posedge clk);
    endtask

    task automatic drain(input int k);
        int budget;
        budget = 0;
        @(negedge clk);
        drive(k, 1'b0, 1'b0, 16'h0, 16'h0);
        while (((k == 0) ? q_a.size() : q_b.size()) != 0) begin
            @(negedge clk);
            budget++;
            if (budget > 40) begin
                fail_only("drain_timeout");
                if (k == 0) q_a.delete(); else q_b.delete();
            end
        end
        @(negedge clk);
    endtask

    // One monitor step: stall/ready against the outstanding-request windows,
    // then response payload, latency and held values.
    task automatic mon(input string tag, ref exp_t q[$], input int w,
                       input logic rv, input logic rdy, input logic stl, input logic er,
                       input logic [15:0] rd, ref logic [15:0] ld, ref logic le);
        logic busy_s;
        logic busy_r;
        busy_s = 1'b0;
        busy_r = 1'b0;
        foreach (q[i]) begin
            if (cyc >= q[i].acc && cyc <= q[i].acc + w) busy_s = 1'b1;
            if (cyc >= q[i].acc + 1 && cyc <= q[i].acc + w + 1) busy_r = 1'b1;
        end
        check({tag, "_stall"}, 32'(stl), 32'(busy_s));
        check({tag, "_req_ready"}, 32'(rdy), 32'(!busy_r));
        if (rv) begin
            if (q.size() == 0) begin
                fail_only({tag, "_unexpected_rsp_valid"});
            end else begin
                exp_t e;
                e = q.pop_front();
                check({tag, "_rsp_rdata"}, 32'(rd), 32'(e.data));
                check({tag, "_rsp_err"}, 32'(er), 32'(e.err));
                check({tag, "_rsp_latency"}, 32'(cyc - e.acc), 32'(w + 1));
                ld = e.data;
                le = e.err;
            end
        end else begin
            check({tag, "_held_rdata"}, 32'(rd), 32'(ld));
            check({tag, "_held_err"}, 32'(er), 32'(le));
            if (q.size() > 0 && cyc > q[0].acc + w + 1) begin
                fail_only({tag, "_missing_rsp"});
                void'(q.pop_front());
            end
        end
    endtask

    always begin
        @(negedge clk);
        #1;
        if (rst_a) mon("a", q_a, WA, bus_a.rsp_valid, bus_a.req_ready, bus_a.stall,
                       bus_a.rsp_err, bus_a.rsp_rdata, last_d_a, last_e_a);
        if (rst_b) mon("b", q_b, WB, bus_b.rsp_valid, bus_b.req_ready, bus_b.stall,
                       bus_b.rsp_err, bus_b.rsp_rdata, last_d_b, last_e_b);
    end

    task automatic run_a();
        logic [15:0] pool[$];
        logic [15:0] old;
        logic [15:0] a;
        int          sel;
        rst_a = 1'b0;
        drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_a = 1'b1;
        #1;
        check("a_reset_req_ready", 32'(bus_a.req_ready), 32'd1);
        check("a_reset_rsp_valid", 32'(bus_a.rsp_valid), 32'd0);
        check("a_reset_rsp_rdata", 32'(bus_a.rsp_rdata), 32'd0);
        check("a_reset_rsp_err", 32'(bus_a.rsp_err), 32'd0);
        check("a_reset_stall", 32'(bus_a.stall), 32'd0);
        check("a_reset_state", 32'(fsm_a), 32'(IDLE));

        issue(0, 1'b1, 16'h0005, 16'hBEEF);
        issue(0, 1'b0, 16'h0005, 16'h0);
        pool = {16'h0000, 16'h0001, 16'h0007, 16'h0010, 16'h0155, 16'h03FF};
        foreach (pool[i]) issue(0, 1'b1, pool[i], 16'($urandom));
        pool.push_back(16'h0005);
        issue(0, 1'b0, 16'h0400, 16'h0);
        issue(0, 1'b1, 16'h0400, 16'h1234);
        issue(0, 1'b0, 16'h0000, 16'h0);
        issue(0, 1'b0, 16'h03FF, 16'h0);

        // Reset held with a store request on the bus: nothing may be written.
        drain(0);
        rst_a = 1'b0;
        drive(0, 1'b1, 1'b1, 16'h0007, 16'h5555);
        repeat (3) @(negedge clk);
        drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
        last_d_a = '0;
        last_e_a = 1'b0;
        rst_a    = 1'b1;
        #1;
        check("a_rst2_req_ready", 32'(bus_a.req_ready), 32'd1);
        check("a_rst2_rsp_rdata", 32'(bus_a.rsp_rdata), 32'd0);
        check("a_rst2_stall", 32'(bus_a.stall), 32'd0);
        issue(0, 1'b0, 16'h0007, 16'h0);

        // Reset in the first wait cycle drops the pending store.
        old = mem_a[16];
        issue(0, 1'b1, 16'h0010, 16'hAAAA);
        @(negedge clk);
        rst_a = 1'b0;
        drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
        @(negedge clk);
        check("a_state_after_mid_wait_reset", 32'(fsm_a), 32'(IDLE));
        q_a.delete();
        mem_a[16] = old;
        last_d_a  = '0;
        last_e_a  = 1'b0;
        rst_a     = 1'b1;
        issue(0, 1'b0, 16'h0010, 16'h0);

        repeat (40) begin
            sel = $urandom_range(0, 9);
            if (sel < 2) a = 16'($urandom_range(DEPTH, 16'hFFFF));
            else         a = pool[$urandom_range(0, pool.size() - 1)];
            issue(0, 1'($urandom_range(0, 1)), a, 16'($urandom));
        end
        drain(0);
    endtask

    task automatic run_b();
        rst_b = 1'b0;
        drive(1, 1'b0, 1'b0, 16'h0, 16'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_b = 1'b1;
        #1;
        check("b_reset_req_ready", 32'(bus_b.req_ready), 32'd1);
        check("b_reset_rsp_valid", 32'(bus_b.rsp_valid), 32'd0);
        for (int i = 0; i < 8; i++) issue(1, 1'b1, 16'(i), 16'($urandom));
        issue(1, 1'b0, 16'h0400, 16'h0);
        for (int i = 0; i < 12; i++) issue(1, 1'b0, 16'($urandom_range(0, 7)), 16'h0);
        issue(1, 1'b1, 16'h03FF, 16'h5A5A);
        issue(1, 1'b0, 16'h03FF, 16'h0);
        issue(1, 1'b1, 16'h0400, 16'h1234);
        issue(1, 1'b0, 16'h0000, 16'h0);
        drain(1);
    endtask

    // Run both instances, then report.
    initial begin
        fork
            run_a();
            run_b();
        join
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
        $fatal(1, "time limit");
    end
endmodule
